// File: rtl/approx_adder_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_adder_err_monitor
//
// Purpose:
//   Downstream error-metric checker for an approximate adder built from
//   `axa` approximate LSB cells and `fa` exact MSB cells (W = axa + fa).
//   For every accepted sample it recomputes the exact sum A+B+Cin, compares
//   it with the adder's own result {ApxCout, ApxSum} and derives the error
//   distance ED = |exact - approx|. Over a window of NSAMP accepted samples
//   it accumulates the number of erroneous samples, the ED sum and the
//   largest ED.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   Start                 begin a window (honoured only in IDLE or DONE)
//   In_valid / In_ready   sample handshake
//   Cin, A, B             adder operands
//   ApxSum, ApxCout       approximate adder result
//   Busy                  window in progress (RUN or DRAIN)
//   Done                  window complete, results valid and held
//   ErrCount              samples with ED != 0
//   ErrDistSum            sum of ED over the window (sized so it cannot wrap)
//   MaxErrDist            largest ED seen in the window
//
// Handshake: a sample transfers on a rising edge where In_valid and
// In_ready are both 1. In_ready is a registered level that is high only in
// RUN and does not depend on In_valid. The source must hold the sample
// stable while In_valid is high and In_ready is low; In_valid and the
// sample lines are ignored whenever In_ready is low.
//
// Timing: a sample accepted at edge k is in S1 after k, in S2 after k+1 and
// in the accumulators after k+2. The window's last accept moves the FSM to
// DRAIN at edge k; DRAIN lasts two cycles, so the edge entering DONE is the
// same edge that folds the last sample into the statistics.
// ---------------------------------------------------------------------------
module approx_adder_err_monitor #(
  parameter int axa   = 3,
  parameter int fa    = 5,
  parameter int NSAMP = 256,
  localparam int W    = axa + fa,
  localparam int CW   = $clog2(NSAMP + 1),
  localparam int SW   = W + 1 + CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          Start,
  input  logic          In_valid,
  output logic          In_ready,
  input  logic          Cin,
  input  logic [W-1:0]  A,
  input  logic [W-1:0]  B,
  input  logic [W-1:0]  ApxSum,
  input  logic          ApxCout,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] ErrCount,
  output logic [SW-1:0] ErrDistSum,
  output logic [W:0]    MaxErrDist
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CW-1:0] LAST_IDX = CW'(NSAMP - 1);

  // -------------------------------------------------------------------------
  // Control FSM (state plus registered handshake/status outputs)
  // -------------------------------------------------------------------------
  state_e        state_q;
  logic [CW-1:0] cnt_q;       // accepted samples so far in this window
  logic          drain_q;     // second DRAIN cycle marker
  logic          in_ready_q;
  logic          busy_q;
  logic          done_q;

  logic accept;
  logic start_take;

  assign accept     = In_valid && in_ready_q;
  // Start only has an effect when no window is in flight.
  assign start_take = Start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            drain_q    <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
          end
        end
        S_RUN: begin
          if (accept) begin
            if (cnt_q == LAST_IDX) begin
              state_q    <= S_DRAIN;
              drain_q    <= 1'b0;
              in_ready_q <= 1'b0;
            end
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign In_ready = in_ready_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

  // -------------------------------------------------------------------------
  // S1: exact sum and approximate result, W+1 bits each
  // -------------------------------------------------------------------------
  logic         s1_valid_q;
  logic [W:0]   s1_exact_q;
  logic [W:0]   s1_apx_q;
  logic [W:0]   exact_d;

  assign exact_d = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_exact_q <= '0;
      s1_apx_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_exact_q <= exact_d;
        s1_apx_q   <= {ApxCout, ApxSum};
      end
    end
  end

  // -------------------------------------------------------------------------
  // S2: error distance. The magnitude is formed by picking the subtraction
  // order with an unsigned compare, so a wrap error (e.g. exact 0x100 vs
  // approx 0x0FF) yields the true distance rather than a modular residue.
  // -------------------------------------------------------------------------
  logic         s2_valid_q;
  logic [W:0]   ed_q;
  logic [W:0]   ed_d;

  always_comb begin
    ed_d = '0;
    if (s1_exact_q >= s1_apx_q) begin
      ed_d = s1_exact_q - s1_apx_q;
    end else begin
      ed_d = s1_apx_q - s1_exact_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      ed_q       <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        ed_q <= ed_d;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Accumulate stage. Results stay visible through DONE and clear on the
  // edge that takes a new Start.
  // -------------------------------------------------------------------------
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [SW-1:0] ed_sum_q, ed_sum_d;
  logic [W:0]    ed_max_q, ed_max_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    ed_sum_d  = ed_sum_q;
    ed_max_d  = ed_max_q;
    if (start_take) begin
      err_cnt_d = '0;
      ed_sum_d  = '0;
      ed_max_d  = '0;
    end else if (s2_valid_q) begin
      err_cnt_d = err_cnt_q + CW'(ed_q != '0);
      ed_sum_d  = ed_sum_q + SW'(ed_q);
      if (ed_q > ed_max_q) begin
        ed_max_d = ed_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      ed_sum_q  <= '0;
      ed_max_q  <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      ed_sum_q  <= ed_sum_d;
      ed_max_q  <= ed_max_d;
    end
  end

  assign ErrCount   = err_cnt_q;
  assign ErrDistSum = ed_sum_q;
  assign MaxErrDist = ed_max_q;

endmodule
